bcd_chain_down_timer: RTL and testbench

Parametrised chain of BCD down-counting digits with borrow propagation, load clamping, a run/stop controller and a terminal-count pulse. It is the generalised successor of the single MOD-6 tens digit in the microwave timer path. One instance replaces the hand-wired seconds/tens/minutes digit cascade and sits between the 1 Hz tick generator and the display/heater control logic. With default parameters it implements an mm:ss countdown from 59:59 to 00:00.

---
 rtl/bcd_chain_down_timer.sv | 120 ++++++++++++
 tb/tb_bcd_chain_down_timer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_chain_down_timer.sv
// Chain of BCD down-counting digits with per-digit moduli, load clamping and a run/stop controller.
// Count updates one clock after tick; done pulses for one cycle after the count reaches zero.
module bcd_chain_down_timer #(
    parameter int                  DIGITS = 4,
    parameter logic [4*DIGITS-1:0] MODS   = 16'h6A6A,
    parameter bit                  WRAP   = 1'b0
) (
    input  logic                  clock,
    input  logic                  clr,
    input  logic                  loadn,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  running,
    output logic                  zero,
    output logic [DIGITS-1:0]     tc,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [4*DIGITS-1:0]   r_digits;
    logic [4*DIGITS-1:0]   w_digits_nxt;
    logic [4*DIGITS-1:0]   w_dec;
    logic [4*DIGITS-1:0]   w_clamp;
    logic                  r_done;
    logic                  w_done_nxt;
    logic [DIGITS-1:0]     w_dig_zero;
    logic [DIGITS-1:0]     w_below_zero;
    logic                  w_running;
    logic                  w_zero;
    logic                  w_dec_zero;

    assign w_running  = (r_state == S_RUN);
    assign w_zero     = ~|r_digits;
    assign w_dec_zero = ~|w_dec;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            localparam logic [3:0] MOD_I = MODS[4*gi +: 4];
            localparam logic [3:0] MAX_I = MOD_I - 4'd1;

            assign w_dig_zero[gi] = (r_digits[4*gi +: 4] == 4'd0);

            // A digit borrows only when every lower digit is already zero.
            if (gi == 0) begin : g_lsd
                assign w_below_zero[gi] = 1'b1;
            end else begin : g_upper
                assign w_below_zero[gi] = &w_dig_zero[gi-1:0];
            end

            assign w_dec[4*gi +: 4] = !w_below_zero[gi] ? r_digits[4*gi +: 4] :
                                      w_dig_zero[gi]    ? MAX_I :
                                                          r_digits[4*gi +: 4] - 4'd1;

            assign w_clamp[4*gi +: 4] = (data[4*gi +: 4] >= MOD_I) ? MAX_I : data[4*gi +: 4];

            assign tc[gi] = w_running & tick & w_dig_zero[gi] & w_below_zero[gi];
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_digits_nxt = r_digits;
        w_done_nxt   = 1'b0;
        if (!loadn) begin
            w_digits_nxt = w_clamp;
            w_state_nxt  = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !(!WRAP && w_zero)) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        w_state_nxt = S_IDLE;
                    end else if (tick) begin
                        w_digits_nxt = w_dec;
                        if (w_dec_zero) begin
                            w_done_nxt = 1'b1;
                            if (!WRAP) begin
                                w_state_nxt = S_DONE;
                            end
                        end
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            r_state  <= S_IDLE;
            r_digits <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_digits <= w_digits_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign digits  = r_digits;
    assign running = w_running;
    assign zero    = w_zero;
    assign done    = r_done;

endmodule

// File: tb/tb_bcd_chain_down_timer.sv
// Scoreboard bench for bcd_chain_down_timer: a stop-at-zero instance and a free-running instance
// share stimulus; each cycle's expected outputs are queued and checked at the falling edge.
module tb_bcd_chain_down_timer;

    logic        clock = 1'b0;
    logic        clr;
    logic        loadn;
    logic [15:0] data;
    logic        start;
    logic        stop;
    logic        tick;

    logic [15:0] digits0, digits1;
    logic        running0, running1;
    logic        zero0, zero1;
    logic [3:0]  tc0, tc1;
    logic        done0, done1;

    bcd_chain_down_timer #(.DIGITS(4), .MODS(16'h6A6A), .WRAP(1'b0)) u_stop (
        .clock(clock), .clr(clr), .loadn(loadn), .data(data), .start(start),
        .stop(stop), .tick(tick), .digits(digits0), .running(running0),
        .zero(zero0), .tc(tc0), .done(done0)
    );

    bcd_chain_down_timer #(.DIGITS(4), .MODS(16'h6A6A), .WRAP(1'b1)) u_wrap (
        .clock(clock), .clr(clr), .loadn(loadn), .data(data), .start(start),
        .stop(stop), .tick(tick), .digits(digits1), .running(running1),
        .zero(zero1), .tc(tc1), .done(done1)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        which;
        logic [15:0] dig;
        logic        run;
        logic        dn;
        logic [3:0]  tcv;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Monitor: one queued expectation per cycle, compared at the falling edge.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [15:0] a_dig;
            logic        a_run, a_dn, a_zero;
            logic [3:0]  a_tc;
            e = sb.pop_front();
            a_dig  = e.which ? digits1  : digits0;
            a_run  = e.which ? running1 : running0;
            a_dn   = e.which ? done1    : done0;
            a_zero = e.which ? zero1    : zero0;
            a_tc   = e.which ? tc1      : tc0;
            vectors++;
            if (a_dig !== e.dig || a_run !== e.run || a_dn !== e.dn ||
                a_zero !== (e.dig == 16'h0) || a_tc !== e.tcv) begin
                miscompares++;
                $display("FAIL %s (inst %0d): got digits=%h running=%b done=%b zero=%b tc=%b, want digits=%h running=%b done=%b zero=%b tc=%b",
                         e.tag, e.which, a_dig, a_run, a_dn, a_zero, a_tc,
                         e.dig, e.run, e.dn, (e.dig == 16'h0), e.tcv);
            end
        end
    end

    task automatic expect_out(input logic which, input logic [15:0] dig, input logic run,
                              input logic dn, input logic [3:0] tcv, input string tag);
        exp_t e;
        e.which = which; e.dig = dig; e.run = run; e.dn = dn; e.tcv = tcv; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic clk();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        loadn = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0;
    endtask

    // mm:ss seconds count to packed BCD {m10, m1, s10, s1}.
    function automatic logic [15:0] to_bcd(input int secs);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        to_bcd = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // Borrow-out pattern seen while ticking from a given seconds value.
    function automatic logic [3:0] tick_tc(input int secs);
        logic [15:0] b;
        b = to_bcd(secs);
        tick_tc[0] = (b[3:0] == 4'd0);
        tick_tc[1] = tick_tc[0] && (b[7:4] == 4'd0);
        tick_tc[2] = tick_tc[1] && (b[11:8] == 4'd0);
        tick_tc[3] = tick_tc[2] && (b[15:12] == 4'd0);
    endfunction

    initial begin
        clr = 1'b1;
        data = 16'h0;
        idle();
        #12 clr = 1'b0;
        clk();

        // Reset state, then load 01:30 and start.
        expect_out(0, 16'h0000, 0, 0, 4'b0000, "reset"); clk();
        loadn = 1'b0; data = 16'h0130;
        expect_out(0, 16'h0000, 0, 0, 4'b0000, "pre_load"); clk();
        idle(); start = 1'b1;
        expect_out(0, 16'h0130, 0, 0, 4'b0000, "load_0130"); clk();

        // 90 ticks from 01:30 down to 00:00, tick every other cycle.
        for (int s = 90; s >= 1; s--) begin
            idle(); tick = 1'b1;
            expect_out(0, to_bcd(s), 1, 0, tick_tc(s), "tick_pre"); clk();
            idle();
            expect_out(0, to_bcd(s - 1), (s != 1), (s == 1), 4'b0000, "tick_post"); clk();
        end
        idle();
        expect_out(0, 16'h0000, 0, 0, 4'b0000, "after_done"); clk();
        start = 1'b1;
        expect_out(0, 16'h0000, 0, 0, 4'b0000, "idle_zero"); clk();
        idle();
        expect_out(0, 16'h0000, 0, 0, 4'b0000, "start_at_zero"); clk();

        // Clamping and start-at-zero suppression.
        loadn = 1'b0; data = 16'h9F7C;
        expect_out(0, 16'h0000, 0, 0, 4'b0000, "pre_clamp"); clk();
        idle();
        expect_out(0, 16'h5959, 0, 0, 4'b0000, "clamp"); clk();
        loadn = 1'b0; data = 16'h0000;
        expect_out(0, 16'h5959, 0, 0, 4'b0000, "pre_load0"); clk();
        idle(); start = 1'b1;
        expect_out(0, 16'h0000, 0, 0, 4'b0000, "load0"); clk();
        idle();
        expect_out(0, 16'h0000, 0, 0, 4'b0000, "load0_start"); clk();

        // Free-running instance: 00:01 -> 00:00 (done, still running) -> 59:59.
        loadn = 1'b0; data = 16'h0001;
        expect_out(0, 16'h0000, 0, 0, 4'b0000, "pre_wrap"); clk();
        idle(); start = 1'b1;
        expect_out(1, 16'h0001, 0, 0, 4'b0000, "w_load"); clk();
        idle(); tick = 1'b1;
        expect_out(1, 16'h0001, 1, 0, 4'b0000, "w_tick1"); clk();
        idle();
        expect_out(1, 16'h0000, 1, 1, 4'b0000, "w_zero_done"); clk();
        expect_out(1, 16'h0000, 1, 0, 4'b0000, "w_hold"); clk();
        tick = 1'b1;
        expect_out(1, 16'h0000, 1, 0, 4'b1111, "w_tc_all"); clk();
        idle();
        expect_out(1, 16'h5959, 1, 0, 4'b0000, "w_reload"); clk();

        // Stop+tick pause, start+tick resume, then decrement from 00:10.
        loadn = 1'b0; data = 16'h0010;
        expect_out(0, 16'h0000, 0, 0, 4'b0000, "pre_10"); clk();
        idle(); start = 1'b1;
        expect_out(0, 16'h0010, 0, 0, 4'b0000, "load_10"); clk();
        idle(); stop = 1'b1; tick = 1'b1;
        expect_out(0, 16'h0010, 1, 0, 4'b0001, "stop_tick_pre"); clk();
        idle(); start = 1'b1; tick = 1'b1;
        expect_out(0, 16'h0010, 0, 0, 4'b0000, "paused"); clk();
        idle();
        expect_out(0, 16'h0010, 1, 0, 4'b0000, "resumed"); clk();
        tick = 1'b1;
        expect_out(0, 16'h0010, 1, 0, 4'b0001, "tick_10"); clk();
        idle();
        expect_out(0, 16'h0009, 1, 0, 4'b0000, "to_09"); clk();

        // Load with tick while running at 00:05.
        loadn = 1'b0; data = 16'h0005;
        expect_out(0, 16'h0009, 1, 0, 4'b0000, "pre_05"); clk();
        idle(); start = 1'b1;
        expect_out(0, 16'h0005, 0, 0, 4'b0000, "load_05"); clk();
        idle(); loadn = 1'b0; data = 16'h0020; tick = 1'b1;
        expect_out(0, 16'h0005, 1, 0, 4'b0000, "ld_tick_pre"); clk();
        idle(); start = 1'b1;
        expect_out(0, 16'h0020, 0, 0, 4'b0000, "ld_tick"); clk();
        idle();
        expect_out(0, 16'h0020, 1, 0, 4'b0000, "run_20"); clk();

        // Asynchronous clear between edges while running.
        #1 clr = 1'b1;
        #1 clr = 1'b0;
        expect_out(0, 16'h0000, 0, 0, 4'b0000, "clr_async"); clk();
        tick = 1'b1;
        expect_out(1, 16'h0000, 0, 0, 4'b0000, "clr_wrap"); clk();
        idle();
        expect_out(0, 16'h0000, 0, 0, 4'b0000, "clr_tick1"); clk();
        tick = 1'b1;
        expect_out(0, 16'h0000, 0, 0, 4'b0000, "clr_tick2"); clk();
        idle();
        expect_out(0, 16'h0000, 0, 0, 4'b0000, "clr_tick3"); clk();

        for (int i = 0; i < 10 && sb.size() > 0; i++) clk();
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
